// File: rtl/npc_mem_pkg.sv
// Shared types and widths for the NPC memory arbiter.
package npc_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 8;

    // Arbiter sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/npc_mem_arb_if.sv
// Bus bundle between the IFU, the LSU, the arbiter and the memory port.
//
// Handshake rules: a request transfers on a cycle where valid and ready are
// both high at the rising edge; valid may not depend on ready. Responses
// (ifu/lsu resp_valid, mem_resp_valid) are one-cycle pulses with no
// backpressure and must be taken by the receiver the cycle they appear.
interface npc_mem_arb_if;
    import npc_mem_pkg::*;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_data;
    logic              ifu_resp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_wen;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_data;
    logic              lsu_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    // Arbiter view.
    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    // Environment view: requesters plus memory.
    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/npc_rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the parent keeps last_owner.
module npc_rr_arb2
    import npc_mem_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_e last_owner,
    output logic   gnt_ifu,
    output logic   gnt_lsu
);

    // A lone requester wins; on a conflict the one not served last wins.
    always_comb begin
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        if (ifu_valid && lsu_valid) begin
            if (last_owner == OWN_IFU) begin
                gnt_lsu = 1'b1;
            end else begin
                gnt_ifu = 1'b1;
            end
        end else begin
            gnt_ifu = ifu_valid;
            gnt_lsu = lsu_valid;
        end
    end

endmodule

// File: rtl/npc_mem_arb.sv
// Shares one memory port between the IFU and LSU, one transaction at a time,
// and turns a hung access into an error response after TIMEOUT cycles.
module npc_mem_arb
    import npc_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic    clk,
    input  logic    rst_n,
    npc_mem_arb_if.slave bus,
    output logic    busy,
    output state_e  dbg_state
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_owner_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              gnt_ifu;
    logic              gnt_lsu;
    logic              accept;
    logic              resp_ok;
    logic              resp_to;
    logic [DATA_W-1:0] resp_word;

    npc_rr_arb2 u_rr (
        .ifu_valid  (bus.ifu_req_valid),
        .lsu_valid  (bus.lsu_req_valid),
        .last_owner (last_owner_q),
        .gnt_ifu    (gnt_ifu),
        .gnt_lsu    (gnt_lsu)
    );

    // Grants are only offered in IDLE and never while reset is asserted.
    assign bus.ifu_req_ready = gnt_ifu && (state_q == IDLE) && rst_n;
    assign bus.lsu_req_ready = gnt_lsu && (state_q == IDLE) && rst_n;
    assign accept            = bus.ifu_req_ready || bus.lsu_req_ready;

    // A memory response in WAIT beats a timeout landing in the same cycle.
    assign resp_ok   = (state_q == WAIT) && bus.mem_resp_valid;
    assign resp_to   = (state_q != IDLE) && (cnt_q == CNT_LAST) && !resp_ok;
    assign resp_word = (resp_ok && !bus.mem_req_wen) ? bus.mem_resp_data : '0;

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // Sequencer: capture on accept, drive memory request, return response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            owner_q            <= OWN_IFU;
            last_owner_q       <= OWN_IFU;
            cnt_q              <= '0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_req_addr   <= '0;
            bus.mem_req_wen    <= 1'b0;
            bus.mem_req_wdata  <= '0;
            bus.mem_req_wmask  <= '0;
            bus.ifu_resp_valid <= 1'b0;
            bus.ifu_resp_err   <= 1'b0;
            bus.ifu_resp_data  <= '0;
            bus.lsu_resp_valid <= 1'b0;
            bus.lsu_resp_err   <= 1'b0;
            bus.lsu_resp_data  <= '0;
        end else begin
            bus.ifu_resp_valid <= 1'b0;
            bus.ifu_resp_err   <= 1'b0;
            bus.ifu_resp_data  <= '0;
            bus.lsu_resp_valid <= 1'b0;
            bus.lsu_resp_err   <= 1'b0;
            bus.lsu_resp_data  <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q           <= REQ;
                        cnt_q             <= '0;
                        bus.mem_req_valid <= 1'b1;
                        if (bus.lsu_req_ready) begin
                            owner_q           <= OWN_LSU;
                            last_owner_q      <= OWN_LSU;
                            bus.mem_req_addr  <= bus.lsu_req_addr;
                            bus.mem_req_wen   <= bus.lsu_req_wen;
                            bus.mem_req_wdata <= bus.lsu_req_wdata;
                            bus.mem_req_wmask <= bus.lsu_req_wmask;
                        end else begin
                            owner_q           <= OWN_IFU;
                            last_owner_q      <= OWN_IFU;
                            bus.mem_req_addr  <= bus.ifu_req_addr;
                            bus.mem_req_wen   <= 1'b0;
                            bus.mem_req_wdata <= '0;
                            bus.mem_req_wmask <= '0;
                        end
                    end
                end
                REQ, WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (resp_ok || resp_to) begin
                        state_q           <= IDLE;
                        bus.mem_req_valid <= 1'b0;
                        if (owner_q == OWN_IFU) begin
                            bus.ifu_resp_valid <= 1'b1;
                            bus.ifu_resp_err   <= resp_to;
                            bus.ifu_resp_data  <= resp_word;
                        end else begin
                            bus.lsu_resp_valid <= 1'b1;
                            bus.lsu_resp_err   <= resp_to;
                            bus.lsu_resp_data  <= resp_word;
                        end
                    end else if ((state_q == REQ) && bus.mem_req_ready) begin
                        state_q           <= WAIT;
                        bus.mem_req_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/npc_mem_arb.md
# npc_mem_arb

Two-requester memory arbiter and transaction sequencer for the NPC core. It shares one downstream memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It accepts one request at a time and sequences it through the memory handshake. It returns the response to the owning requester and converts a hung memory access into an error response after a bounded timeout.

## Interface
- TIMEOUT, 255: cycles allowed in REQ+WAIT before an error response is issued; legal range 2..65535.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle when high with valid.
- ifu_req_addr  in  32  fetch address.
- ifu_resp_valid  out  1  one-cycle pulse; IFU response present.
- ifu_resp_data  out  32  fetched word.
- ifu_resp_err  out  1  timeout error flag, valid with ifu_resp_valid.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_addr  in  32  access address.
- lsu_req_wen  in  1  1 = store, 0 = load.
- lsu_req_wdata  in  32  store data.
- lsu_req_wmask  in  8  byte write mask, passed through unchanged.
- lsu_resp_valid  out  1  one-cycle pulse; LSU response present (loads and stores).
- lsu_resp_data  out  32  load data; 0 for stores.
- lsu_resp_err  out  1  timeout error flag.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  out  32/1/32/8  registered request fields.
- mem_resp_valid  in  1  memory response; no backpressure.
- mem_resp_data  in  32  memory read data.
- busy  out  1  high in REQ or WAIT.

## Operation
- States: IDLE, REQ, WAIT. Reset → IDLE.
- In IDLE:
  - ifu_req_ready/lsu_req_ready equal the arbiter grant: a requester with valid high is granted if it is alone.
  - If both requesters are valid, the one not served last is granted. last_owner resets to IFU, so the first conflict goes to the LSU.
  - On accept, addr/wen/wdata/wmask are captured (IFU: wen=0, wmask=0), the owner and last_owner are recorded, the timeout counter is cleared, and the state goes to REQ.
- In REQ and WAIT, both req_ready outputs are 0.
- REQ: mem_req_valid=1 with the captured fields held stable. When mem_req_ready=1, go to WAIT.
- WAIT: when mem_resp_valid=1, next cycle the owner's resp_valid=1, resp_data=mem_resp_data (0 if wen), resp_err=0. The state returns to IDLE.
- Timeout:
  - The counter (width clog2(TIMEOUT+1)) increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT-1 with no completing handshake, the owner gets resp_valid=1, resp_err=1, resp_data=0, and the state returns to IDLE. mem_req_valid drops.
  - If mem_resp_valid arrives in the same cycle the timeout fires, the normal response wins.
- mem_resp_valid received in IDLE or REQ (stale/late) is ignored.
- Requesters must accept responses unconditionally.
- Reset mid-transaction returns to IDLE: no response is issued and mem_req_valid deasserts in the cycle after rst_n is sampled low.
- Reset values: all resp_valid/resp_err/resp_data = 0; mem_req_valid = 0; mem_req_* fields = 0; busy = 0; both req_ready = 0 while rst_n = 0.

## Timing
- Accept at cycle T. mem_req_valid is high from T+1.
- Best case: mem_req_ready at T+1 and mem_resp_valid at T+2 give resp_valid at T+3. Minimum latency is 3 cycles.
- Responses are registered. IDLE is re-entered in the same cycle as the resp_valid pulse, so a new request can be accepted at T+3 (back-to-back).
- req_ready is combinational from state and the valids, with no dependency on ready inputs. mem_req_* outputs are registered only.

## Structure
- Package npc_mem_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2);
  - owner encoding (OWN_IFU=1'b0, OWN_LSU=1'b1);
  - ADDR_W=32, DATA_W=32, MASK_W=8.
- Sub-module npc_rr_arb2: a 2-way round-robin grant from two valids plus last_owner. It is purely combinational; last_owner is stored in the parent.

## Test plan
- IFU only, addr 0x80000000, memory ready immediately, resp 0x00000413 one cycle later → ifu_resp_valid at T+3, data 0x00000413, err 0; lsu_resp_valid stays 0.
- LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0f, mem_req_ready delayed 4 cycles → mem_req fields stable throughout REQ; lsu_resp_valid with data 0, err 0.
- Both valid in IDLE, three times in a row → grants LSU, IFU, LSU; the loser's ready stays 0 until granted.
- Memory never asserts mem_resp_valid, TIMEOUT=8 → owner resp_valid with err=1 after 8 cycles in REQ/WAIT. A later spurious mem_resp_valid in IDLE produces no response.
- mem_resp_valid in the exact cycle the timeout fires → normal response with err=0 and the memory data.
- rst_n low for one cycle during WAIT → next cycle IDLE, busy=0, mem_req_valid=0, no resp_valid pulse. The next IFU request completes normally and the first conflict after reset goes to the LSU.
